// File: rtl/tlb_translate_pkg.sv
// Shared TLB types: search key/result, page-table entry, exception codes.
// Included first so the translate stage and micro-TLB agree on layouts.
package tlb_params;

    localparam int VPN2_WIDTH = 19;
    localparam int ASID_WIDTH = 8;
    localparam int PFN_WIDTH  = 20;

    typedef struct packed {
        logic [VPN2_WIDTH-1:0] vpn2;
        logic                  odd_page;
        logic [ASID_WIDTH-1:0] asid;
    } search_request_t;

    typedef struct packed {
        logic [PFN_WIDTH-1:0] page_frame_number;
        logic [2:0]           is_cached;
        logic                 is_dirty;
        logic                 is_valid;
        logic                 is_global;
    } entry_t;

    typedef struct packed {
        logic   found;
        entry_t entry;
    } search_result_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_REFILL   = 2'd1,
        EXC_INVALID  = 2'd2,
        EXC_MODIFIED = 2'd3
    } tlb_exc_e;

    function automatic tlb_exc_e classify(input logic found, input entry_t e, input logic is_store);
        if (!found)                  return EXC_REFILL;
        else if (!e.is_valid)        return EXC_INVALID;
        else if (is_store && !e.is_dirty) return EXC_MODIFIED;
        else                         return EXC_NONE;
    endfunction

endpackage

// File: rtl/tlb_translate_micro_entry.sv
// One-entry micro-TLB holding the last selected half-entry; hit needs exact vpn+odd match.
// Combinational hit, registered refill; any invalidate source masks the hit in the same cycle.
module tlb_micro_entry
    import tlb_params::*;
(
    input  logic            clock,
    input  logic            reset,
    input  search_request_t key,
    input  logic            tlb_write,
    input  logic            flush,
    input  logic            refill,
    input  entry_t          refill_entry,
    output logic            hit,
    output entry_t          hit_entry
);

    logic                  vld;
    logic [VPN2_WIDTH-1:0] vpn;
    logic                  odd;
    logic [ASID_WIDTH-1:0] asid;
    entry_t                entry;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  asid_changed;
    logic                  inval;

    assign asid_changed = (key.asid != asid_q);
    assign inval        = tlb_write || flush || asid_changed;

    assign hit = vld && !inval && (vpn == key.vpn2) && (odd == key.odd_page)
                 && (entry.is_global || (asid == key.asid));
    assign hit_entry = entry;

    always_ff @(posedge clock) begin
        asid_q <= key.asid;
        if (reset) begin
            vld <= 1'b0;
        end else if (inval) begin
            vld <= 1'b0;
        end else if (refill) begin
            vld   <= 1'b1;
            vpn   <= key.vpn2;
            odd   <= key.odd_page;
            asid  <= key.asid;
            entry <= refill_entry;
        end
    end

endmodule

// File: rtl/tlb_translate.sv
// Virtual-to-physical translation: kseg0/1 decode, micro-TLB, else TLB search result.
// Latency 1 cycle; single output register, req_ready = !resp_valid || resp_ready (0 during flush).
module tlb_translate
    import tlb_params::*;
#(
    parameter int PA_WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_vaddr,
    input  logic                req_is_store,
    input  logic [7:0]          cp0_asid,
    input  logic                flush,
    input  logic                tlb_write,
    output search_request_t     search_req,
    input  search_result_t      search_res,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [PA_WIDTH-1:0] resp_paddr,
    output logic [2:0]          resp_cached,
    output logic [1:0]          resp_exc
);

    logic          accept;
    logic          unmapped;
    logic          micro_hit;
    entry_t        micro_entry;
    entry_t        use_entry;
    logic          found;
    logic          refill;
    tlb_exc_e      nxt_exc;
    logic [PA_WIDTH-1:0] nxt_paddr;
    logic [2:0]    nxt_cached;

    assign search_req.vpn2     = req_vaddr[31:13];
    assign search_req.odd_page = req_vaddr[12];
    assign search_req.asid     = cp0_asid;

    assign req_ready = (!resp_valid || resp_ready) && !flush;
    assign accept    = req_valid && req_ready;
    assign unmapped  = (req_vaddr[31:30] == 2'b10);

    // Only misses that produced a usable mapping are worth caching.
    assign refill = accept && !unmapped && !micro_hit
                    && search_res.found && search_res.entry.is_valid;

    tlb_micro_entry u_micro (
        .clock        (clock),
        .reset        (reset),
        .key          (search_req),
        .tlb_write    (tlb_write),
        .flush        (flush),
        .refill       (refill),
        .refill_entry (search_res.entry),
        .hit          (micro_hit),
        .hit_entry    (micro_entry)
    );

    always_comb begin
        use_entry  = micro_hit ? micro_entry : search_res.entry;
        found      = micro_hit || search_res.found;
        nxt_exc    = EXC_NONE;
        nxt_paddr  = PA_WIDTH'(req_vaddr[28:0]);
        nxt_cached = req_vaddr[29] ? 3'd2 : 3'd3;
        if (!unmapped) begin
            nxt_exc = classify(found, use_entry, req_is_store);
            if (nxt_exc == EXC_NONE) begin
                nxt_paddr  = PA_WIDTH'({use_entry.page_frame_number, req_vaddr[11:0]});
                nxt_cached = use_entry.is_cached;
            end else begin
                nxt_paddr  = PA_WIDTH'(req_vaddr);
                nxt_cached = 3'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_paddr  <= '0;
            resp_cached <= '0;
            resp_exc    <= '0;
        end else if (flush) begin
            resp_valid <= 1'b0;
        end else if (accept) begin
            resp_valid  <= 1'b1;
            resp_paddr  <= nxt_paddr;
            resp_cached <= nxt_cached;
            resp_exc    <= nxt_exc;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tlb_translate.sv
// Directed bench for tlb_translate with a behavioural reference model and per-cycle compare.
module tb_tlb_translate;
    import tlb_params::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_vaddr;
    logic            req_is_store;
    logic [7:0]      cp0_asid;
    logic            flush;
    logic            tlb_write;
    search_request_t search_req;
    search_result_t  search_res;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_paddr;
    logic [2:0]      resp_cached;
    logic [1:0]      resp_exc;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    tlb_translate #(.PA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_is_store(req_is_store), .cp0_asid(cp0_asid), .flush(flush),
        .tlb_write(tlb_write), .search_req(search_req), .search_res(search_res),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
        .resp_cached(resp_cached), .resp_exc(resp_exc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the remembered translation and the pending response.
    bit          m_valid;
    int unsigned m_paddr, m_cached, m_exc;
    bit          mu_valid, mu_odd, mu_glob, mu_dirty, mu_evalid;
    int unsigned mu_vpn, mu_asid, mu_pfn, mu_cached;
    int unsigned prev_asid;

    always @(posedge clock) begin
        bit ready, acc, chg, hit, fnd, vld, dirty, glob, mapped;
        int unsigned vpn, pfn, cch, exc;
        prev_asid = prev_asid;
        if (reset) begin
            m_valid = 0; m_paddr = 0; m_cached = 0; m_exc = 0; mu_valid = 0;
        end else begin
            chg    = (cp0_asid != prev_asid);
            ready  = (!m_valid || resp_ready) && !flush;
            acc    = req_valid && ready;
            vpn    = req_vaddr >> 13;
            mapped = (req_vaddr[31:30] != 2'b10);
            hit    = mu_valid && !tlb_write && !chg && mu_vpn == vpn && mu_odd == req_vaddr[12]
                     && (mu_glob || mu_asid == cp0_asid);
            if (hit) begin
                fnd = 1; vld = mu_evalid; dirty = mu_dirty; pfn = mu_pfn; cch = mu_cached; glob = mu_glob;
            end else begin
                fnd = search_res.found; vld = search_res.entry.is_valid;
                dirty = search_res.entry.is_dirty; pfn = search_res.entry.page_frame_number;
                cch = search_res.entry.is_cached; glob = search_res.entry.is_global;
            end
            if (!fnd) exc = 1;
            else if (!vld) exc = 2;
            else if (req_is_store && !dirty) exc = 3;
            else exc = 0;
            if (flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1;
                if (!mapped) begin
                    m_paddr = req_vaddr & 32'h1FFF_FFFF; m_cached = req_vaddr[29] ? 2 : 3; m_exc = 0;
                end else if (exc == 0) begin
                    m_paddr = pfn * 4096 + (req_vaddr & 32'hFFF); m_cached = cch; m_exc = 0;
                end else begin
                    m_paddr = req_vaddr; m_cached = 0; m_exc = exc;
                end
            end else if (resp_ready) m_valid = 0;
            if (tlb_write || flush || chg) mu_valid = 0;
            else if (acc && mapped && !hit && fnd && vld) begin
                mu_valid = 1; mu_vpn = vpn; mu_odd = req_vaddr[12]; mu_asid = cp0_asid;
                mu_glob = glob; mu_dirty = dirty; mu_evalid = vld; mu_pfn = pfn; mu_cached = cch;
            end
        end
        prev_asid = cp0_asid;
    end

    always @(negedge clock) begin
        if (started && !reset) begin
            chk("req_ready", req_ready, (!m_valid || resp_ready) && !flush);
            chk("resp_valid", resp_valid, m_valid);
            chk("search_key", search_req, {req_vaddr[31:12], cp0_asid});
            if (m_valid) begin
                chk("resp_paddr", resp_paddr, m_paddr);
                chk("resp_cached", resp_cached, m_cached);
                chk("resp_exc", resp_exc, m_exc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_tlb(input bit f, input logic [19:0] pfn, input logic [2:0] c,
                           input bit d, input bit v, input bit g);
        search_res.found                   = f;
        search_res.entry.page_frame_number = pfn;
        search_res.entry.is_cached         = c;
        search_res.entry.is_dirty          = d;
        search_res.entry.is_valid          = v;
        search_res.entry.is_global         = g;
    endtask

    task automatic req(input logic [31:0] va, input bit st);
        req_valid = 1; req_vaddr = va; req_is_store = st;
        tick();
    endtask

    task automatic expect_resp(input string name, input logic [31:0] pa, input logic [2:0] c, input logic [1:0] e);
        chk({name, "_valid"}, resp_valid, 1);
        chk({name, "_paddr"}, resp_paddr, pa);
        chk({name, "_cached"}, resp_cached, c);
        chk({name, "_exc"}, resp_exc, e);
    endtask

    initial begin
        reset = 1; req_valid = 0; req_vaddr = 0; req_is_store = 0; cp0_asid = 8'd5;
        flush = 0; tlb_write = 0; resp_ready = 1;
        set_tlb(0, 20'h0, 3'd0, 0, 0, 0);
        tick(); started = 1; tick();
        reset = 0;
        tick();
        chk("rst_valid", resp_valid, 0);
        chk("rst_paddr", resp_paddr, 0);
        chk("rst_ready", req_ready, 1);

        req(32'hBFC0_0100, 0);           expect_resp("kseg1", 32'h1FC0_0100, 3'd2, 2'd0);
        set_tlb(1, 20'h12345, 3'd3, 1, 1, 0);
        req(32'h0040_3004, 0);           expect_resp("map_miss", 32'h1234_5004, 3'd3, 2'd0);
        set_tlb(0, 20'h0, 3'd0, 0, 0, 0);
        req(32'h8000_1234, 0);           expect_resp("kseg0", 32'h0000_1234, 3'd3, 2'd0);
        req(32'h0040_3004, 0);           expect_resp("map_hit", 32'h1234_5004, 3'd3, 2'd0);

        set_tlb(1, 20'h0ABCD, 3'd2, 0, 1, 0);
        req(32'h0080_0000, 1);           expect_resp("st_mod", 32'h0080_0000, 3'd0, 2'd3);
        set_tlb(0, 20'h0, 3'd0, 0, 0, 0);
        req(32'h0080_0000, 1);           expect_resp("st_mod_hit", 32'h0080_0000, 3'd0, 2'd3);
        req(32'h0080_0000, 0);           expect_resp("ld_hit", 32'h0ABC_D000, 3'd2, 2'd0);
        req(32'h00C0_0000, 0);           expect_resp("refill", 32'h00C0_0000, 3'd0, 2'd1);
        set_tlb(1, 20'h11111, 3'd3, 1, 0, 0);
        req(32'h00C0_1000, 0);           expect_resp("invalid", 32'h00C0_1000, 3'd0, 2'd2);

        set_tlb(1, 20'h12345, 3'd3, 1, 1, 0);
        req(32'h0040_3004, 0);
        req_valid = 0; cp0_asid = 8'd6;
        tick();
        set_tlb(1, 20'h54321, 3'd3, 1, 1, 0);
        req(32'h0040_3004, 0);           expect_resp("asid_miss", 32'h5432_1004, 3'd3, 2'd0);
        tlb_write = 1;
        set_tlb(1, 20'hAAAAA, 3'd3, 1, 1, 0);
        req(32'h0040_3004, 0);           expect_resp("tlbw_bypass", 32'hAAAA_A004, 3'd3, 2'd0);
        tlb_write = 0;
        set_tlb(0, 20'h0, 3'd0, 0, 0, 0);
        req(32'h0040_3004, 0);           expect_resp("tlbw_inval", 32'h0040_3004, 3'd0, 2'd1);

        req_valid = 0; tick();
        resp_ready = 0;
        req(32'hBFC0_0000, 0);           expect_resp("stall_a", 32'h1FC0_0000, 3'd2, 2'd0);
        req_vaddr = 32'h8000_0010;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", req_ready, 0);
            tick();
            expect_resp("stall_hold", 32'h1FC0_0000, 3'd2, 2'd0);
        end
        resp_ready = 1;
        #1 chk("release_ready", req_ready, 1);
        tick();                          expect_resp("stall_b", 32'h0000_0010, 3'd3, 2'd0);

        req_valid = 0; tick();
        resp_ready = 0;
        req(32'hBFC0_0200, 0);           expect_resp("pre_flush", 32'h1FC0_0200, 3'd2, 2'd0);
        flush = 1;
        #1 chk("flush_ready", req_ready, 0);
        tick();
        chk("flush_valid", resp_valid, 0);
        flush = 0;

        req(32'hBFC0_0300, 0);           expect_resp("pre_reset", 32'h1FC0_0300, 3'd2, 2'd0);
        reset = 1;
        tick();
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_paddr", resp_paddr, 0);
        chk("mid_rst_cached", resp_cached, 0);
        chk("mid_rst_exc", resp_exc, 0);
        reset = 0; req_valid = 0; resp_ready = 1;
        tick();
        chk("post_rst_ready", req_ready, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
